// File: rtl/player_motion_ctl.sv
// Per-frame motion controller for one fencer sprite.
// Synchronises the buttons and advances walk, horizontal clamping, a
// ballistic jump and a two-frame leg animation once per video frame,
// on the rising edge of vsync_in.
//
// Ports:
//   clk          pixel clock
//   reset        asynchronous, active-high reset
//   left/right   move buttons (asynchronous, synchronised here)
//   jump         jump button (asynchronous, synchronised here)
//   vsync_in     vsync from the timing chain; rising edge = frame tick
//   xpos, ypos   sprite position (head top-left) to the draw stage
//   facing_left  1 = mirror sprite to face left
//   legs_sel     0 = legs frame A, 1 = legs frame B
//   state        00 IDLE, 01 WALK, 10 AIR
module player_motion_ctl #(
  parameter int X_INIT   = 75,
  parameter int Y_INIT   = 600,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 960,
  parameter int STEP     = 4,
  parameter int JUMP_V0  = 12,
  parameter int GRAVITY  = 1,
  parameter int ANIM_DIV = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        left,
  input  logic        right,
  input  logic        jump,
  input  logic        vsync_in,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        facing_left,
  output logic        legs_sel,
  output logic [1:0]  state
);

  localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  localparam logic signed [12:0] STEP_S = 13'(STEP);
  localparam logic signed [12:0] XMIN_S = 13'(X_MIN);
  localparam logic signed [12:0] XMAX_S = 13'(X_MAX);
  localparam logic signed [12:0] YGND_S = 13'(Y_INIT);
  localparam logic [11:0]        Y_TAKE = 12'(Y_INIT - JUMP_V0);
  localparam logic signed [7:0]  V_TAKE = 8'(JUMP_V0 - GRAVITY);
  localparam logic signed [7:0]  G_S    = 8'(GRAVITY);
  localparam logic [CW-1:0]      CNT_WRAP = CW'(ANIM_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WALK = 2'b01,
    AIR  = 2'b10
  } st_t;

  st_t st_q, st_d;

  logic l_m, l_s, r_m, r_s, j_m, j_s;
  logic vs_d, tick;

  logic signed [7:0]  vel_q, vel_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [11:0]        x_d, y_d;
  logic               legs_d, face_d;

  logic signed [12:0] dir, x_sum, y_air;
  logic               moving;

  assign tick  = vsync_in & ~vs_d;
  assign state = st_q;

  // Horizontal step and saturating clamp, valid in every state.
  always_comb begin
    dir = '0;
    if (l_s & ~r_s)      dir = -STEP_S;
    else if (r_s & ~l_s) dir = STEP_S;
  end

  assign moving = (dir != 13'sd0);
  assign x_sum  = $signed({1'b0, xpos}) + dir;
  // vel is signed; sign-extend before subtracting from the unsigned ypos.
  assign y_air  = $signed({1'b0, ypos}) - $signed({{5{vel_q[7]}}, vel_q});

  always_comb begin
    st_d   = st_q;
    y_d    = ypos;
    vel_d  = vel_q;
    cnt_d  = cnt_q;
    legs_d = legs_sel;
    face_d = facing_left;

    if (x_sum < XMIN_S)      x_d = XMIN_S[11:0];
    else if (x_sum > XMAX_S) x_d = XMAX_S[11:0];
    else                     x_d = x_sum[11:0];

    if (l_s & ~r_s)      face_d = 1'b1;
    else if (r_s & ~l_s) face_d = 1'b0;

    case (st_q)
      IDLE, WALK: begin
        if (j_s) begin
          // Takeoff: first airborne position is already applied this tick.
          st_d   = AIR;
          y_d    = Y_TAKE;
          vel_d  = V_TAKE;
          legs_d = 1'b1;
        end else if (moving) begin
          st_d = WALK;
          if (cnt_q == CNT_WRAP) begin
            legs_d = ~legs_sel;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          st_d = IDLE;
          if (st_q == WALK) begin
            legs_d = 1'b0;
            cnt_d  = '0;
          end
        end
      end
      AIR: begin
        if (y_air >= YGND_S) begin
          // Land; jump is not looked at until the next tick.
          st_d   = moving ? WALK : IDLE;
          y_d    = YGND_S[11:0];
          vel_d  = '0;
          legs_d = 1'b0;
          cnt_d  = '0;
        end else begin
          y_d    = y_air[11:0];
          vel_d  = vel_q - G_S;
          legs_d = 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {l_m, l_s, r_m, r_s, j_m, j_s} <= '0;
      vs_d        <= 1'b0;
      st_q        <= IDLE;
      xpos        <= 12'(X_INIT);
      ypos        <= 12'(Y_INIT);
      vel_q       <= '0;
      cnt_q       <= '0;
      legs_sel    <= 1'b0;
      facing_left <= 1'b0;
    end else begin
      l_m  <= left;  l_s <= l_m;
      r_m  <= right; r_s <= r_m;
      j_m  <= jump;  j_s <= j_m;
      vs_d <= vsync_in;
      if (tick) begin
        st_q        <= st_d;
        xpos        <= x_d;
        ypos        <= y_d;
        vel_q       <= vel_d;
        cnt_q       <= cnt_d;
        legs_sel    <= legs_d;
        facing_left <= face_d;
      end
    end
  end

endmodule

// File: tb/tb_player_motion_ctl.sv
module tb_player_motion_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic        left, right, jump, vsync_in;
  logic [11:0] xpos, ypos;
  logic        facing_left, legs_sel;
  logic [1:0]  state;

  int n_vec = 0;
  int n_err = 0;

  player_motion_ctl dut (
    .clk(clk), .reset(reset), .left(left), .right(right), .jump(jump),
    .vsync_in(vsync_in), .xpos(xpos), .ypos(ypos),
    .facing_left(facing_left), .legs_sel(legs_sel), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame: low long enough for buttons to pass the synchroniser,
  // then a short vsync pulse; outputs are stable on return.
  task automatic frame();
    repeat (4) @(negedge clk);
    vsync_in = 1'b1;
    repeat (2) @(negedge clk);
    vsync_in = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Hand-computed jump trajectory, ticks 1..25 after takeoff.
  int y_tbl [25] = '{588, 577, 567, 558, 550, 543, 537, 532, 528, 525,
                     523, 522, 522, 523, 525, 528, 532, 537, 543, 550,
                     558, 567, 577, 588, 600};

  initial begin
    reset = 1'b1; left = 1'b0; right = 1'b0; jump = 1'b0; vsync_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_x", xpos, 75);
    chk("rst_y", ypos, 600);
    chk("rst_st", state, 0);
    chk("rst_legs", legs_sel, 0);
    chk("rst_face", facing_left, 0);
    reset = 1'b0;

    // Idle frames
    for (int k = 1; k <= 3; k++) begin
      frame();
      chk("idle_x", xpos, 75);
      chk("idle_y", ypos, 600);
      chk("idle_st", state, 0);
    end
    chk("idle_legs", legs_sel, 0);
    chk("idle_face", facing_left, 0);

    // Walk left into the X_MIN clamp
    left = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      frame();
      chk("left_x", xpos, (75 - 4*k < 0) ? 0 : 75 - 4*k);
      chk("left_st", state, 1);
    end
    chk("left_face", facing_left, 1);
    left = 1'b0;
    frame();
    chk("left_rel_st", state, 0);
    chk("left_rel_legs", legs_sel, 0);
    chk("left_rel_face", facing_left, 1);

    // Both buttons cancel out
    do_reset();
    left = 1'b1; right = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      frame();
      chk("both_x", xpos, 75);
      chk("both_st", state, 0);
      chk("both_face", facing_left, 0);
    end
    left = 1'b0; right = 1'b0;

    // Walk right: leg animation toggles every 8 walk ticks
    for (int k = 1; k <= 16; k++) begin
      right = 1'b1;
      frame();
      chk("right_x", xpos, 75 + 4*k);
      chk("right_st", state, 1);
      chk("right_legs", legs_sel, (k >= 8 && k < 16) ? 1 : 0);
    end
    right = 1'b0;
    frame();
    chk("right_rel_st", state, 0);
    chk("right_rel_legs", legs_sel, 0);
    chk("right_rel_x", xpos, 139);

    // Single-frame jump pulse: full ballistic arc
    jump = 1'b1;
    frame();
    jump = 1'b0;
    chk("jump_y", ypos, y_tbl[0]);
    chk("jump_st", state, 2);
    chk("jump_legs", legs_sel, 1);
    for (int k = 2; k <= 25; k++) begin
      frame();
      chk("air_y", ypos, y_tbl[k-1]);
      chk("air_st", state, (k == 25) ? 0 : 2);
      chk("air_legs", legs_sel, (k == 25) ? 0 : 1);
      chk("air_x", xpos, 139);
    end

    // Walk right into the X_MAX clamp
    right = 1'b1;
    for (int k = 1; k <= 210; k++) begin
      frame();
      chk("rmax_x", xpos, (139 + 4*k > 960) ? 960 : 139 + 4*k);
    end
    right = 1'b0;
    frame();
    chk("rmax_rel_st", state, 0);

    // Reset mid-jump, with vsync rising during reset
    jump = 1'b1;
    frame();
    jump = 1'b0;
    for (int k = 2; k <= 5; k++) frame();
    chk("mid_y5", ypos, 550);
    chk("mid_st5", state, 2);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_x", xpos, 75);
    chk("mid_rst_y", ypos, 600);
    chk("mid_rst_st", state, 0);
    chk("mid_rst_legs", legs_sel, 0);
    @(negedge clk);
    vsync_in = 1'b1;
    right = 1'b1;
    repeat (2) @(negedge clk);
    chk("vs_in_rst_x", xpos, 75);
    reset = 1'b0;
    // vsync held high: one tick right after release (right not yet synced),
    // no further ticks even though right is now visible.
    repeat (18) @(negedge clk);
    chk("vs_hold_x", xpos, 75);
    chk("vs_hold_st", state, 0);
    vsync_in = 1'b0;
    frame();
    chk("vs_next_x", xpos, 79);
    chk("vs_next_st", state, 1);
    right = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
